// File: rtl/alu_cmd_sequencer.sv
// Command-side driver for a 4-bit combinational ALU: FIFO-buffered commands,
// registered operand/control drive, settle-timed capture and result handshake.
module alu_cmd_sequencer #(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  input  logic       cmd_chain,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic       alu_l,
  output logic       alu_m,
  output logic       alu_n,
  input  logic [3:0] alu_s,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] res_data,
  output logic [2:0] res_op,
  output logic       busy,
  output logic       err_op
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [2:0] OP_RSVD = 3'b111;

  logic [11:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             not_full_q, not_full_d;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       acc_q, acc_d;
  logic [3:0]       alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic             res_valid_q, res_valid_d;
  logic [3:0]       res_data_q, res_data_d;
  logic [2:0]       res_op_q, res_op_d;
  logic             err_op_q, err_op_d;

  logic        push, pop;
  logic [11:0] head;
  logic [2:0]  head_op;
  logic [3:0]  head_a, head_b;
  logic        head_chain;

  // Gated with rst so the port reads 0 while reset is held, 1 right after release.
  assign cmd_ready = not_full_q & ~rst;
  assign push      = cmd_valid & cmd_ready;
  assign pop       = (state_q == S_IDLE) && (count_q != '0);

  assign head       = mem_q[rd_ptr_q];
  assign head_op    = head[11:9];
  assign head_a     = head[8:5];
  assign head_b     = head[4:1];
  assign head_chain = head[0];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_op, cmd_a, cmd_b, cmd_chain};
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_op_d    = res_op_q;
    err_op_d    = 1'b0;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    count_d    = count_q + CW'(push) - CW'(pop);
    not_full_d = (count_d != CW'(DEPTH));

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
          if (head_op == OP_RSVD) begin
            err_op_d = 1'b1;
          end else begin
            alu_a_d  = head_chain ? acc_q : head_a;
            alu_b_d  = head_b;
            alu_op_d = head_op;
            cnt_d    = '0;
            state_d  = S_DRIVE;
          end
        end
      end
      S_DRIVE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(SETTLE - 1)) begin
          res_data_d  = alu_s;
          acc_d       = alu_s;
          res_op_d    = alu_op_q;
          res_valid_d = 1'b1;
          state_d     = S_HOLD;
        end
      end
      S_HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      not_full_q  <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_op_q    <= '0;
      err_op_q    <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      not_full_q  <= not_full_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_op_q    <= res_op_d;
      err_op_q    <= err_op_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_l     = alu_op_q[2];
  assign alu_m     = alu_op_q[1];
  assign alu_n     = alu_op_q[0];
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_op    = res_op_q;
  assign err_op    = err_op_q;
  assign busy      = (count_q != '0) || (state_q != S_IDLE);

endmodule
